// File: rtl/ram_pkg.sv
// ============================================================================
// ram_pkg : shared types, constants and helpers for the sweep-cleared RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int C_INIT_VAL_DEFAULT = 0;

  // Bounded loop keeps this usable as a constant function in every tool.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_core.sv
// ============================================================================
// ram_core : inferred single-port synchronous RAM, registered write-first read
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_core
  import ram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_rd_zero,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Only the read register is reset; the array contents come from the sweep.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else if (i_re) begin
      if (i_rd_zero)  r_rdata <= '0;
      else if (i_we)  r_rdata <= i_wdata;
      else            r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ram_sweep_ctrl.sv
// ============================================================================
// ram_sweep_ctrl : parametrised RAM with automatic clear sweep and read strobe
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_sweep_ctrl
  import ram_pkg::*;
#(
  parameter int              DATA_W   = 4,
  parameter int              ADDR_W   = 5,
  parameter int              DEPTH    = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(C_INIT_VAL_DEFAULT)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wren,
  input  logic              rden,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              clr_done
);

  localparam int                 CORE_AW = clog2(DEPTH);
  localparam logic [CORE_AW-1:0] C_LAST  = CORE_AW'(DEPTH - 1);

  state_t             r_state, w_state_nxt;
  logic [CORE_AW-1:0] r_cnt, w_cnt_nxt;
  logic               r_clr_done, w_clr_done_nxt;
  logic               r_rvalid, w_rvalid_nxt;

  logic               w_in_range;
  logic               w_core_we;
  logic               w_core_re;
  logic [CORE_AW-1:0] w_core_addr;
  logic [DATA_W-1:0]  w_core_wdata;

  assign w_in_range = (32'(addr) < 32'(DEPTH));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_done <= w_clr_done_nxt;
      r_rvalid   <= w_rvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_clr_done_nxt = 1'b0;
    w_rvalid_nxt   = 1'b0;
    w_core_we      = 1'b0;
    w_core_re      = 1'b0;
    w_core_addr    = addr[CORE_AW-1:0];
    w_core_wdata   = wdata;

    case (r_state)
      ST_CLEAR: begin
        w_core_we    = 1'b1;
        w_core_addr  = r_cnt;
        w_core_wdata = INIT_VAL;
        // A fresh clr request abandons the current pass without a done pulse.
        if (clr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_cnt_nxt      = '0;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CORE_AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_core_we    = wren & w_in_range;
          w_core_re    = rden;
          w_rvalid_nxt = rden;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (CORE_AW)
  ) u_core (
    .clock     (clock),
    .resetn    (resetn),
    .i_we      (w_core_we),
    .i_re      (w_core_re),
    .i_rd_zero (~w_in_range),
    .i_addr    (w_core_addr),
    .i_wdata   (w_core_wdata),
    .o_rdata   (rdata)
  );

  assign busy     = (r_state == ST_CLEAR);
  assign clr_done = r_clr_done;
  assign rvalid   = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_ram_sweep_ctrl.sv
// ============================================================================
// tb_ram_sweep_ctrl : scoreboard bench for ram_sweep_ctrl (three configurations)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_sweep_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn_s [3];
  logic       clr_s    [3];
  logic       wren_s   [3];
  logic       rden_s   [3];
  logic [4:0] addr_s   [3];
  logic [3:0] wdata_s  [3];
  logic [3:0] rdata_s  [3];
  logic       rvalid_s [3];
  logic       busy_s   [3];
  logic       done_s   [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  // dut 0: defaults, dut 1: INIT_VAL=0xF, dut 2: DEPTH=20
  ram_sweep_ctrl u_dut0 (
    .clock(clock), .resetn(resetn_s[0]), .clr(clr_s[0]), .wren(wren_s[0]),
    .rden(rden_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
    .rvalid(rvalid_s[0]), .busy(busy_s[0]), .clr_done(done_s[0]));

  ram_sweep_ctrl #(.INIT_VAL(4'hF)) u_dut1 (
    .clock(clock), .resetn(resetn_s[1]), .clr(clr_s[1]), .wren(wren_s[1]),
    .rden(rden_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
    .rvalid(rvalid_s[1]), .busy(busy_s[1]), .clr_done(done_s[1]));

  ram_sweep_ctrl #(.DEPTH(20)) u_dut2 (
    .clock(clock), .resetn(resetn_s[2]), .clr(clr_s[2]), .wren(wren_s[2]),
    .rden(rden_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]),
    .rvalid(rvalid_s[2]), .busy(busy_s[2]), .clr_done(done_s[2]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int k, input logic [3:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Monitor: every rvalid pulse consumes one expected word.
  always @(negedge clock) begin : monitor
    logic [3:0] e;
    bit         have;
    for (int k = 0; k < 3; k++) begin
      if (rvalid_s[k] === 1'b1) begin
        have = 1'b0;
        e    = 4'h0;
        case (k)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) check($sformatf("unexpected_rvalid_dut%0d", k), 1, 0);
        else       check($sformatf("rdata_dut%0d", k), int'(rdata_s[k]), int'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int k, input int a, input int d);
    wren_s[k]  = 1'b1;
    addr_s[k]  = 5'(a);
    wdata_s[k] = 4'(d);
    tick();
    wren_s[k]  = 1'b0;
  endtask

  task automatic rd(input int k, input int a, input int e);
    rden_s[k] = 1'b1;
    addr_s[k] = 5'(a);
    push(k, 4'(e));
    tick();
    rden_s[k] = 1'b0;
    check($sformatf("rvalid_after_read_dut%0d", k), int'(rvalid_s[k]), 1);
  endtask

  task automatic pulse_clr(input int k);
    clr_s[k] = 1'b1;
    tick();
    clr_s[k] = 1'b0;
    check($sformatf("busy_after_clr_dut%0d", k), int'(busy_s[k]), 1);
  endtask

  task automatic wait_sweep(input int k, input int exp_edges, input string name);
    int n;
    int stray;
    n     = 0;
    stray = 0;
    do begin
      tick();
      n++;
      if (busy_s[k] && (done_s[k] || rvalid_s[k])) stray++;
    end while (busy_s[k] && n < 500);
    wren_s[k] = 1'b0;
    rden_s[k] = 1'b0;
    check({name, "_busy_edges"}, n, exp_edges);
    check({name, "_done_pulse"}, int'(done_s[k]), 1);
    check({name, "_stray_strobe"}, stray, 0);
    tick();
    check({name, "_done_low"}, int'(done_s[k]), 0);
  endtask

  task automatic busy_steps(input int k, input int n, input string name);
    int bad;
    bad = 0;
    repeat (n) begin
      tick();
      if (!busy_s[k] || done_s[k]) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      resetn_s[k] = 1'b0; clr_s[k] = 1'b0; wren_s[k] = 1'b0;
      rden_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
    end
    #22;
    check("reset_rdata", int'(rdata_s[0]), 0);
    check("reset_rvalid", int'(rvalid_s[0]), 0);
    check("reset_busy", int'(busy_s[0]), 1);
    check("reset_clr_done", int'(done_s[0]), 0);

    // 1: power-up sweep then every word reads as zero
    tick();
    resetn_s[0] = 1'b1;
    wait_sweep(0, 32, "rst0");
    for (int a = 0; a < 32; a++) rd(0, a, 0);

    // 2: write then read, then rdata holds with rvalid low
    wr(0, 5, 4'hA);
    rd(0, 5, 4'hA);
    tick();
    check("idle_rvalid_low", int'(rvalid_s[0]), 0);
    check("idle_rdata_hold", int'(rdata_s[0]), 4'hA);

    // 3: same-edge read and write is write-first
    wren_s[0] = 1'b1; rden_s[0] = 1'b1; addr_s[0] = 5'd9; wdata_s[0] = 4'h3;
    push(0, 4'h3);
    tick();
    wren_s[0] = 1'b0; rden_s[0] = 1'b0;
    rd(0, 9, 4'h3);

    // 4: pattern fill, clear with writes/reads attempted throughout the sweep
    for (int a = 0; a < 32; a++) wr(0, a, a & 15);
    rd(0, 17, 1);
    rd(0, 30, 14);
    pulse_clr(0);
    wren_s[0] = 1'b1; rden_s[0] = 1'b1; addr_s[0] = 5'd2; wdata_s[0] = 4'h5;
    wait_sweep(0, 32, "clr0");
    for (int a = 0; a < 32; a++) rd(0, a, 0);

    tick();
    resetn_s[1] = 1'b1;
    wait_sweep(1, 32, "rst1");
    rd(1, 4, 4'hF);
    for (int a = 0; a < 32; a++) wr(1, a, a & 15);
    rd(1, 6, 6);
    pulse_clr(1);
    wren_s[1] = 1'b1; addr_s[1] = 5'd1; wdata_s[1] = 4'h2;
    wait_sweep(1, 32, "clr1");
    for (int a = 0; a < 32; a++) rd(1, a, 4'hF);

    // 5a: clr at sweep edge 10 restarts without a done for the aborted pass
    pulse_clr(0);
    busy_steps(0, 9, "pre_restart_busy");
    clr_s[0] = 1'b1;
    tick();
    clr_s[0] = 1'b0;
    wait_sweep(0, 32, "restart0");

    // 5b: asynchronous reset at sweep edge 12
    wr(0, 3, 6);
    rd(0, 3, 6);
    pulse_clr(0);
    busy_steps(0, 11, "pre_reset_busy");
    check("sweep_rdata_hold", int'(rdata_s[0]), 6);
    #3;
    resetn_s[0] = 1'b0;
    #1;
    check("midsweep_reset_rdata", int'(rdata_s[0]), 0);
    check("midsweep_reset_busy", int'(busy_s[0]), 1);
    check("midsweep_reset_rvalid", int'(rvalid_s[0]), 0);
    check("midsweep_reset_done", int'(done_s[0]), 0);
    tick();
    tick();
    resetn_s[0] = 1'b1;
    wait_sweep(0, 32, "resweep0");
    rd(0, 3, 0);

    // 6: DEPTH=20, out-of-range access and short sweep
    resetn_s[2] = 1'b1;
    wait_sweep(2, 20, "rst2");
    wr(2, 25, 7);
    rd(2, 25, 0);
    wr(2, 19, 9);
    rd(2, 19, 9);
    rd(2, 5, 0);
    rd(2, 9, 0);
    rd(2, 25, 0);
    pulse_clr(2);
    wait_sweep(2, 20, "clr2");
    rd(2, 19, 0);

    tick();
    tick();
    check("scoreboard_empty_dut0", q0.size(), 0);
    check("scoreboard_empty_dut1", q1.size(), 0);
    check("scoreboard_empty_dut2", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
